// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared types and constants for the USB link-layer receive path.
//   state_type      : receive control unit FSM states (3 bits)
//   PID_CLS_*       : PID class codes taken from pid[1:0]
//   SYNC_BYTE_DEF   : shift-register value expected after the SYNC field
//   *_BYTES         : post-PID byte counts required per packet class
// -----------------------------------------------------------------------------
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RCV_SYNC  = 3'd1,
        RCV_PID   = 3'd2,
        RCV_BYTES = 3'd3,
        WAIT_EOP  = 3'd4,
        EOP_END   = 3'd5,
        ERROR     = 3'd6,
        ERR_IDLE  = 3'd7
    } state_type;

    localparam logic [1:0] PID_CLS_SPECIAL = 2'b00;
    localparam logic [1:0] PID_CLS_TOKEN   = 2'b01;
    localparam logic [1:0] PID_CLS_HS      = 2'b10;
    localparam logic [1:0] PID_CLS_DATA    = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

    localparam int TOKEN_BYTES    = 2;
    localparam int HS_BYTES       = 0;
    localparam int DATA_MIN_BYTES = 2;

endpackage

// File: rtl/usb_bit_counter.sv
// -----------------------------------------------------------------------------
// usb_bit_counter
// Counts received (destuffed) bits modulo 8 and raises byte_rdy for one cycle
// after the bit that completes a byte.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : restart counting at a packet start
//   shift_enable  : one pulse per received bit
//   eop           : end-of-packet level; bits flagged with eop are not counted
//   bit_cnt       : bits received in the current byte (0..7)
//   byte_rdy      : registered pulse, shift register holds a full byte
// -----------------------------------------------------------------------------
module usb_bit_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_enable,
    input  logic       eop,
    output logic [2:0] bit_cnt,
    output logic       byte_rdy
);

    logic count_bit;

    assign count_bit = shift_enable & ~eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            byte_rdy <= 1'b0;
        end else if (clear) begin
            bit_cnt  <= 3'd0;
            byte_rdy <= 1'b0;
        end else begin
            // byte_rdy lands in the cycle after the 7->0 wrap, when the
            // shift register has settled on the completed byte.
            byte_rdy <= count_bit & (bit_cnt == 3'd7);
            if (count_bit) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_rcu.sv
// -----------------------------------------------------------------------------
// usb_rcu
// Receive control unit: walks an incoming packet through SYNC, PID, post-PID
// bytes and EOP. Data-packet bytes are strobed into the RX FIFO, token bytes
// are captured, protocol errors set a sticky flag.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   d_edge        : first line transition of a packet (pulse)
//   shift_enable  : one pulse per received bit
//   eop           : end-of-packet level, qualified by shift_enable
//   rcv_byte      : shift-register contents
//   rcving        : packet in progress
//   w_enable      : RX FIFO write strobe, data is rcv_byte
//   r_error       : sticky protocol error, cleared at the next packet start
//   rx_pid        : last valid PID
//   tok_bytes     : {byte1, byte0} of the last token
//   pkt_done      : one-cycle pulse on error-free packet completion
//
// Handshake on the FIFO side: w_enable is a single-cycle strobe; the FIFO
// takes rcv_byte on every clock edge where w_enable is high, no back-pressure.
//
// WAIT_EOP is the tail of error recovery: the EOP has been seen and the FSM
// waits for the line to leave EOP before arming for the next packet.
// -----------------------------------------------------------------------------
module usb_rcu
    import usb_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_BYTES = 66,
    parameter int         CNT_W     = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_edge,
    input  logic        shift_enable,
    input  logic        eop,
    input  logic [7:0]  rcv_byte,
    output logic        rcving,
    output logic        w_enable,
    output logic        r_error,
    output logic [3:0]  rx_pid,
    output logic [15:0] tok_bytes,
    output logic        pkt_done
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] TOK_CNT  = CNT_W'(TOKEN_BYTES);
    localparam logic [CNT_W-1:0] HS_CNT   = CNT_W'(HS_BYTES);
    localparam logic [CNT_W-1:0] DMIN_CNT = CNT_W'(DATA_MIN_BYTES);

    state_type        state;
    logic [2:0]       bit_cnt;
    logic             byte_rdy;
    logic [CNT_W-1:0] byte_cnt;
    logic             start;
    logic             eop_strobe;
    logic [1:0]       cls;
    logic             byte_err;
    logic [CNT_W-1:0] cnt_upd;
    logic             len_ok;
    logic             pid_ok;

    assign start      = d_edge & ((state == IDLE) | (state == ERR_IDLE));
    assign eop_strobe = shift_enable & eop;
    assign cls        = rx_pid[1:0];
    assign pid_ok     = (rcv_byte[7:4] == ~rcv_byte[3:0]);

    usb_bit_counter u_bit_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (start),
        .shift_enable (shift_enable),
        .eop          (eop),
        .bit_cnt      (bit_cnt),
        .byte_rdy     (byte_rdy)
    );

    // A byte that arrives together with EOP is counted before the length check.
    assign cnt_upd = byte_rdy ? byte_cnt + CNT_W'(1) : byte_cnt;

    always_comb begin
        byte_err = 1'b0;
        len_ok   = 1'b0;
        case (cls)
            PID_CLS_DATA: begin
                byte_err = (byte_cnt == MAX_CNT);
                len_ok   = (cnt_upd >= DMIN_CNT) && (cnt_upd <= MAX_CNT);
            end
            PID_CLS_TOKEN: begin
                byte_err = (byte_cnt == TOK_CNT);
                len_ok   = (cnt_upd == TOK_CNT);
            end
            PID_CLS_HS: begin
                byte_err = 1'b1;
                len_ok   = (cnt_upd == HS_CNT);
            end
            default: begin
                byte_err = 1'b1;
                len_ok   = 1'b0;
            end
        endcase
    end

    // Decoded from registered state so the strobe coincides with byte_rdy
    // while rcv_byte is valid; reset drops it immediately.
    assign w_enable = (state == RCV_BYTES) & byte_rdy & (cls == PID_CLS_DATA) &
                      (byte_cnt != MAX_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            rcving    <= 1'b0;
            r_error   <= 1'b0;
            rx_pid    <= 4'd0;
            tok_bytes <= 16'd0;
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE, ERR_IDLE: begin
                    if (d_edge) begin
                        state   <= RCV_SYNC;
                        rcving  <= 1'b1;
                        r_error <= 1'b0;
                    end
                end
                RCV_SYNC: begin
                    if (eop_strobe) begin
                        state   <= WAIT_EOP;
                        r_error <= 1'b1;
                    end else if (byte_rdy) begin
                        if (rcv_byte == SYNC_BYTE) begin
                            state <= RCV_PID;
                        end else begin
                            state   <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                RCV_PID: begin
                    if (eop_strobe) begin
                        state   <= WAIT_EOP;
                        r_error <= 1'b1;
                    end else if (byte_rdy) begin
                        if (pid_ok) begin
                            rx_pid   <= rcv_byte[3:0];
                            byte_cnt <= '0;
                            state    <= RCV_BYTES;
                        end else begin
                            state   <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                RCV_BYTES: begin
                    if (byte_rdy) begin
                        byte_cnt <= cnt_upd;
                        if (cls == PID_CLS_TOKEN && byte_cnt == CNT_W'(0)) begin
                            tok_bytes[7:0] <= rcv_byte;
                        end
                        if (cls == PID_CLS_TOKEN && byte_cnt == CNT_W'(1)) begin
                            tok_bytes[15:8] <= rcv_byte;
                        end
                    end
                    if (byte_rdy && byte_err) begin
                        // If the EOP is already here, skip waiting for it.
                        state   <= eop_strobe ? WAIT_EOP : ERROR;
                        r_error <= 1'b1;
                    end else if (eop_strobe) begin
                        if (bit_cnt != 3'd0 || !len_ok) begin
                            state   <= WAIT_EOP;
                            r_error <= 1'b1;
                        end else begin
                            state <= EOP_END;
                        end
                    end
                end
                EOP_END: begin
                    if (!eop) begin
                        pkt_done <= 1'b1;
                        rcving   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ERROR: begin
                    r_error <= 1'b1;
                    if (eop_strobe) begin
                        state <= WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    r_error <= 1'b1;
                    if (!eop) begin
                        rcving <= 1'b0;
                        state  <= ERR_IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rcu.sv
module tb_usb_rcu;

  logic        clk;
  logic        rst;
  logic        d_edge;
  logic        shift_enable;
  logic        eop;
  logic [7:0]  rcv_byte;
  logic        rcving;
  logic        w_enable;
  logic        r_error;
  logic [3:0]  rx_pid;
  logic [15:0] tok_bytes;
  logic        pkt_done;

  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  int done_cnt = 0;

  usb_rcu dut (
    .clk          (clk),
    .rst          (rst),
    .d_edge       (d_edge),
    .shift_enable (shift_enable),
    .eop          (eop),
    .rcv_byte     (rcv_byte),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .rx_pid       (rx_pid),
    .tok_bytes    (tok_bytes),
    .pkt_done     (pkt_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: every FIFO write must match the next expected byte
  always @(negedge clk) begin
    if (!rst && w_enable) begin
      wen_cnt++;
      if (exp_q.size() == 0) check("wen_extra", 32'(rcv_byte), 32'hxbad);
      else check("wen_data", 32'(rcv_byte), 32'(exp_q.pop_front()));
    end
    if (!rst && pkt_done) done_cnt++;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    d_edge = 1'b1;
    step();
    d_edge = 1'b0;
    step();
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1;
      step();
      shift_enable = 1'b0;
      step();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(7);
    rcv_byte = b;
    send_bits(1);
  endtask

  task automatic send_data(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b);
  endtask

  task automatic send_eop();
    eop = 1'b1;
    shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
    step();
    step();
    eop = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic clr_counts();
    wen_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic data_pkt(input logic [7:0] pid, input int n, input int n_exp);
    start_pkt();
    send_byte(8'h80);
    send_byte(pid);
    for (int i = 0; i < n; i++) begin
      if (i < n_exp) send_data(8'($urandom_range(0, 255)));
      else send_byte(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    rst = 1'b1;
    d_edge = 1'b0;
    shift_enable = 1'b0;
    eop = 1'b0;
    rcv_byte = 8'h00;
    step();
    step();
    check("rst_rcving", 32'(rcving), 0);
    check("rst_wen", 32'(w_enable), 0);
    check("rst_rerr", 32'(r_error), 0);
    check("rst_pid", 32'(rx_pid), 0);
    check("rst_tok", 32'(tok_bytes), 0);
    check("rst_done", 32'(pkt_done), 0);
    rst = 1'b0;
    step();

    // DATA0, 4 payload + 2 CRC
    clr_counts();
    start_pkt();
    check("d0_rcving", 32'(rcving), 1);
    send_byte(8'h80);
    send_byte(8'hC3);
    for (int i = 0; i < 6; i++) send_data(8'($urandom_range(0, 255)));
    send_eop();
    check("d0_wen", wen_cnt, 6);
    check("d0_q", exp_q.size(), 0);
    check("d0_pid", 32'(rx_pid), 3);
    check("d0_done", done_cnt, 1);
    check("d0_rerr", 32'(r_error), 0);
    check("d0_rcving_end", 32'(rcving), 0);

    // OUT token
    clr_counts();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hE1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_eop();
    check("tok_bytes", 32'(tok_bytes), 32'h3412);
    check("tok_pid", 32'(rx_pid), 1);
    check("tok_wen", wen_cnt, 0);
    check("tok_done", done_cnt, 1);

    // bad SYNC, then ACK clears the error
    clr_counts();
    start_pkt();
    send_byte(8'h81);
    send_byte(8'hC3);
    check("sync_rerr", 32'(r_error), 1);
    send_eop();
    check("sync_rerr_eop", 32'(r_error), 1);
    check("sync_rcving", 32'(rcving), 0);
    check("sync_done", done_cnt, 0);
    start_pkt();
    check("ack_rerr_clr", 32'(r_error), 0);
    send_byte(8'h80);
    send_byte(8'hD2);
    send_eop();
    check("ack_done", done_cnt, 1);
    check("ack_pid", 32'(rx_pid), 2);
    check("ack_rerr", 32'(r_error), 0);

    // bad PID check
    clr_counts();
    data_pkt(8'hC4, 3, 0);
    check("pid_rerr", 32'(r_error), 1);
    check("pid_wen", wen_cnt, 0);
    check("pid_keep", 32'(rx_pid), 2);
    send_eop();
    check("pid_done", done_cnt, 0);

    // EOP 3 bits into the 3rd data byte
    clr_counts();
    data_pkt(8'hC3, 2, 2);
    send_bits(3);
    send_eop();
    check("part_rerr", 32'(r_error), 1);
    check("part_wen", wen_cnt, 2);
    check("part_done", done_cnt, 0);

    // maximum-length data packet completes
    clr_counts();
    data_pkt(8'hC3, 66, 66);
    send_eop();
    check("max_wen", wen_cnt, 66);
    check("max_done", done_cnt, 1);
    check("max_rerr", 32'(r_error), 0);

    // 67 post-PID bytes
    clr_counts();
    data_pkt(8'hC3, 67, 66);
    check("ovf_rerr", 32'(r_error), 1);
    send_eop();
    check("ovf_wen", wen_cnt, 66);
    check("ovf_done", done_cnt, 0);

    // data packet of one byte is too short
    clr_counts();
    data_pkt(8'hC3, 1, 1);
    send_eop();
    check("short_rerr", 32'(r_error), 1);
    check("short_done", done_cnt, 0);

    // handshake carrying a byte
    clr_counts();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hD2);
    send_byte(8'h55);
    send_eop();
    check("hs_rerr", 32'(r_error), 1);
    check("hs_done", done_cnt, 0);

    // reset in the cycle a data byte is being written
    clr_counts();
    data_pkt(8'hC3, 2, 2);
    send_bits(7);
    rcv_byte = 8'hA5;
    shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
    check("rst_mid_wen_pre", 32'(w_enable), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_wen", 32'(w_enable), 0);
    check("rst_mid_rcving", 32'(rcving), 0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_mid_wcnt", wen_cnt, 2);
    check("rst_mid_pid", 32'(rx_pid), 0);
    clr_counts();
    data_pkt(8'h4B, 3, 3);
    send_eop();
    check("post_rst_wen", wen_cnt, 3);
    check("post_rst_done", done_cnt, 1);
    check("post_rst_pid", 32'(rx_pid), 32'hB);
    check("post_rst_rerr", 32'(r_error), 0);
    check("post_rst_q", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
